// File: rtl/tank_pkg.sv
// Shared types and constants for the tank patrol sequencer.
// Holds the heading encoding, the patrol FSM states and the power-up route.
package tank_pkg;

    typedef enum logic [2:0] {
        UP    = 3'd1,
        RIGHT = 3'd2,
        LEFT  = 3'd3,
        DOWN  = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        MOVE  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    // One route entry is {dir[2:0], len[7:0]}
    localparam int ENTRY_W = 11;

    // Default patrol loop: a rectangle, repeated for deeper tables
    localparam dir_t       DEF_DIR_0 = UP;
    localparam dir_t       DEF_DIR_1 = RIGHT;
    localparam dir_t       DEF_DIR_2 = DOWN;
    localparam dir_t       DEF_DIR_3 = LEFT;
    localparam logic [7:0] DEF_LEN_0 = 8'd200;
    localparam logic [7:0] DEF_LEN_1 = 8'd100;
    localparam logic [7:0] DEF_LEN_2 = 8'd200;
    localparam logic [7:0] DEF_LEN_3 = 8'd100;

    // Reset contents of table slot idx
    function automatic logic [ENTRY_W-1:0] default_entry(input int idx);
        logic [ENTRY_W-1:0] e;
        case (idx % 4)
            0:       e = {DEF_DIR_0, DEF_LEN_0};
            1:       e = {DEF_DIR_1, DEF_LEN_1};
            2:       e = {DEF_DIR_2, DEF_LEN_2};
            default: e = {DEF_DIR_3, DEF_LEN_3};
        endcase
        return e;
    endfunction

    // Only the four compass headings are legal; anything else means "stand still"
    function automatic logic dir_valid(input logic [2:0] d);
        return (d >= 3'd1) && (d <= 3'd4);
    endfunction

endpackage

// File: rtl/tank_route_table.sv
// Route table: NUM_SEG entries of {dir, len}, one write port, async read.
// Entries come back to the default rectangle patrol on Reset.
module tank_route_table
    import tank_pkg::*;
#(
    parameter  int NUM_SEG = 4,
    localparam int AW      = $clog2(NUM_SEG)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [2:0]    wr_dir,
    input  logic [7:0]    wr_len,
    input  logic [AW-1:0] rd_addr,
    output logic [2:0]    rd_dir,
    output logic [7:0]    rd_len
);

    logic [ENTRY_W-1:0] mem [NUM_SEG];

    // Storage: reset reloads the default route, otherwise accept raw writes
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                mem[i] <= default_entry(i);
            end
        end else if (wr_en) begin
            mem[wr_addr] <= {wr_dir, wr_len};
        end
    end

    assign rd_dir = mem[rd_addr][ENTRY_W-1:8];
    assign rd_len = mem[rd_addr][7:0];

endmodule

// File: rtl/tank_patrol_seq.sv
// Tank patrol sequencer: walks the route table, issuing one move_req per
// frame tick for each segment, then pausing PAUSE_FRAMES ticks.
// Optional macro TANK_PATROL_FIRE_EN adds a fire pulse at each segment end.
module tank_patrol_seq
    import tank_pkg::*;
#(
    parameter  int NUM_SEG      = 4,
    parameter  int PAUSE_FRAMES = 8,
    localparam int AW           = $clog2(NUM_SEG)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          frame_clk,
    input  logic          enable,
    input  logic          blocked,
    input  logic          seg_wr_en,
    input  logic [AW-1:0] seg_wr_addr,
    input  logic [2:0]    seg_wr_dir,
    input  logic [7:0]    seg_wr_len,
    output logic [2:0]    tank_dir,
    output logic          move_req,
    output logic          fire_req,
    output logic [AW-1:0] seg_idx,
    output logic          busy
);

    localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);

    state_t     state;
    state_t     next_state;
    logic       frame_q;
    logic       tick;
    logic [7:0] cur_len;
    logic [7:0] frame_cnt;
    logic [2:0] rd_dir;
    logic [7:0] rd_len;
    logic [7:0] load_len;
    logic       do_load;
    logic       cnt_inc;
    logic       cnt_clr;
    logic       seg_adv;

    tank_route_table #(
        .NUM_SEG (NUM_SEG)
    ) u_table (
        .Clk     (Clk),
        .Reset   (Reset),
        .wr_en   (seg_wr_en),
        .wr_addr (seg_wr_addr),
        .wr_dir  (seg_wr_dir),
        .wr_len  (seg_wr_len),
        .rd_addr (seg_idx),
        .rd_dir  (rd_dir),
        .rd_len  (rd_len)
    );

    // An illegal heading is loaded as a zero-length segment
    assign load_len = dir_valid(rd_dir) ? rd_len : 8'd0;
    assign busy     = (state != IDLE);

    // Frame tick: one-Clk pulse the cycle after a rising frame_clk is sampled
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_q <= 1'b0;
            tick    <= 1'b0;
        end else begin
            frame_q <= frame_clk;
            tick    <= frame_clk & ~frame_q;
        end
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus move pulse and datapath strobes
    always_comb begin
        next_state = state;
        move_req   = 1'b0;
        do_load    = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        seg_adv    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                do_load    = 1'b1;
                cnt_clr    = 1'b1;
                next_state = (load_len == 8'd0) ? PAUSE : MOVE;
            end
            MOVE: begin
                if (tick && enable && !blocked) begin
                    move_req = 1'b1;
                    if (frame_cnt == cur_len - 8'd1) begin
                        cnt_clr    = 1'b1;
                        next_state = PAUSE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (tick && enable) begin
                    if (frame_cnt == PAUSE_LAST) begin
                        cnt_clr    = 1'b1;
                        seg_adv    = 1'b1;
                        next_state = LOAD;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Segment datapath: latched heading/length, frame counter, segment index
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tank_dir  <= UP;
            cur_len   <= 8'd0;
            frame_cnt <= 8'd0;
            seg_idx   <= '0;
        end else begin
            if (do_load) begin
                tank_dir <= rd_dir;
                cur_len  <= load_len;
            end
            if (cnt_clr) begin
                frame_cnt <= 8'd0;
            end else if (cnt_inc) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (seg_adv) begin
                seg_idx <= seg_idx + 1'b1;
            end
        end
    end

`ifdef TANK_PATROL_FIRE_EN
    // Fire once as a movement segment finishes and the pause begins
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fire_req <= 1'b0;
        end else begin
            fire_req <= (state == MOVE) && (next_state == PAUSE);
        end
    end
`else
    assign fire_req = 1'b0;
`endif

endmodule

// File: tb/tb_tank_patrol_seq.sv
// Testbench for tank_patrol_seq: random frames and table writes against a
// segment-level patrol model, checked by a move/fire scoreboard.
// Honours TANK_PATROL_FIRE_EN the same way the design does.
module tb_tank_patrol_seq;

    localparam int NUM_SEG      = 4;
    localparam int PAUSE_FRAMES = 8;
    localparam int AW           = 2;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          frame_clk;
    logic          enable;
    logic          blocked;
    logic          seg_wr_en;
    logic [AW-1:0] seg_wr_addr;
    logic [2:0]    seg_wr_dir;
    logic [7:0]    seg_wr_len;
    logic [2:0]    tank_dir;
    logic          move_req;
    logic          fire_req;
    logic [AW-1:0] seg_idx;
    logic          busy;

    tank_patrol_seq #(
        .NUM_SEG      (NUM_SEG),
        .PAUSE_FRAMES (PAUSE_FRAMES)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .enable      (enable),
        .blocked     (blocked),
        .seg_wr_en   (seg_wr_en),
        .seg_wr_addr (seg_wr_addr),
        .seg_wr_dir  (seg_wr_dir),
        .seg_wr_len  (seg_wr_len),
        .tank_dir    (tank_dir),
        .move_req    (move_req),
        .fire_req    (fire_req),
        .seg_idx     (seg_idx),
        .busy        (busy)
    );

    // 50 MHz system clock
    always #10 Clk = ~Clk;

    typedef struct {
        int seg;
        int dir;
    } move_t;

    int    checks   = 0;
    int    failures = 0;
    bit    mon_en   = 1'b0;
    move_t move_q[$];
    int    fire_q[$];
    move_t mon_m;
    int    mon_f;

    // Reference model: a table copy and how many moves / pause ticks remain
    logic [10:0] mtab [NUM_SEG];
    int          m_phase;   // 0 not started, 1 moving, 2 pausing
    int          m_seg;
    int          m_dir;
    int          m_left;
    int          m_hold;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        int dirs [4] = '{1, 2, 4, 3};
        int lens [4] = '{200, 100, 200, 100};
        for (int i = 0; i < NUM_SEG; i++) begin
            mtab[i] = {3'(dirs[i % 4]), 8'(lens[i % 4])};
        end
        m_phase = 0;
        m_seg   = 0;
        m_dir   = 1;
        m_left  = 0;
        m_hold  = 0;
        move_q.delete();
        fire_q.delete();
    endfunction

    function automatic void model_load(input int s);
        int d;
        int l;
        d     = int'(mtab[s][10:8]);
        l     = int'(mtab[s][7:0]);
        m_seg = s;
        if (d >= 1 && d <= 4 && l != 0) begin
            m_phase = 1;
            m_left  = l;
            m_dir   = d;
        end else begin
            m_phase = 2;
            m_hold  = PAUSE_FRAMES;
        end
    endfunction

    // One frame tick as the patrol rules see it
    function automatic void model_tick(input bit en, input bit blk);
        move_t mv;
        if (m_phase == 0) begin
            if (!en) return;
            model_load(0);
        end
        if (m_phase == 1) begin
            if (en && !blk) begin
                mv.seg = m_seg;
                mv.dir = m_dir;
                move_q.push_back(mv);
                m_left--;
                if (m_left == 0) begin
`ifdef TANK_PATROL_FIRE_EN
                    fire_q.push_back(m_seg);
`endif
                    m_phase = 2;
                    m_hold  = PAUSE_FRAMES;
                end
            end
        end else if (m_phase == 2) begin
            if (en) begin
                m_hold--;
                if (m_hold == 0) model_load((m_seg + 1) % NUM_SEG);
            end
        end
    endfunction

    // Monitor: every move/fire pulse is matched against the scoreboard
    always @(negedge Clk) begin
        if (mon_en) begin
            if (move_req === 1'b1) begin
                if (move_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_move actual=1 required=0 seg=%0d", seg_idx);
                end else begin
                    mon_m = move_q.pop_front();
                    check("move_seg", 32'(seg_idx), 32'(mon_m.seg));
                    check("move_dir", 32'(tank_dir), 32'(mon_m.dir));
                end
            end else if (move_req !== 1'b0) begin
                check("move_known", 32'(move_req), 32'd0);
            end
`ifdef TANK_PATROL_FIRE_EN
            if (fire_req === 1'b1) begin
                if (fire_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_fire actual=1 required=0");
                end else begin
                    mon_f = fire_q.pop_front();
                    check("fire_seg", 32'(seg_idx), 32'(mon_f));
                end
            end else if (fire_req !== 1'b0) begin
                check("fire_known", 32'(fire_req), 32'd0);
            end
`else
            if (fire_req !== 1'b0) check("fire_off", 32'(fire_req), 32'd0);
`endif
        end
    end

    // One frame_clk period carrying one tick; optional Reset on the tick cycle
    task automatic applyFrame(input bit en, input bit blk, input bit rst_on_tick);
        @(negedge Clk);
        enable  = en;
        blocked = blk;
        @(negedge Clk);
        frame_clk = 1'b1;
        model_tick(en, blk);
        @(negedge Clk);
        if (rst_on_tick) Reset = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        if (rst_on_tick) begin
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_dir", 32'(tank_dir), 32'd1);
            check("rst_move", 32'(move_req), 32'd0);
            check("rst_seg", 32'(seg_idx), 32'd0);
            check("rst_fire", 32'(fire_req), 32'd0);
            enable = 1'b0;
            Reset  = 1'b0;
            model_reset();
        end
        @(negedge Clk);
    endtask

    task automatic writeEntry(input int addr, input int dir, input int len);
        @(negedge Clk);
        seg_wr_en   = 1'b1;
        seg_wr_addr = AW'(addr);
        seg_wr_dir  = 3'(dir);
        seg_wr_len  = 8'(len);
        mtab[addr]  = {3'(dir), 8'(len)};
        @(negedge Clk);
        seg_wr_en = 1'b0;
    endtask

    initial begin
        Reset       = 1'b1;
        frame_clk   = 1'b0;
        enable      = 1'b0;
        blocked     = 1'b0;
        seg_wr_en   = 1'b0;
        seg_wr_addr = '0;
        seg_wr_dir  = '0;
        seg_wr_len  = '0;
        model_reset();
        repeat (3) @(negedge Clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_seg", 32'(seg_idx), 32'd0);
        check("reset_dir", 32'(tank_dir), 32'd1);
        check("reset_move", 32'(move_req), 32'd0);
        check("reset_fire", 32'(fire_req), 32'd0);
        Reset  = 1'b0;
        mon_en = 1'b1;

        // Default route with a collision hold inside segment 0
        for (int i = 0; i < 50; i++) applyFrame(1'b1, 1'b0, 1'b0);
        check("busy_run", 32'(busy), 32'd1);
        for (int i = 0; i < 10; i++) applyFrame(1'b1, 1'b1, 1'b0);
        // Reroute segment 1 and empty segment 2 while segment 0 runs
        writeEntry(1, 3, 3);
        writeEntry(2, 2, 0);
        for (int i = 0; i < 300; i++) applyFrame(1'b1, 1'b0, 1'b0);
        check("loop_seg", 32'(seg_idx), 32'(m_seg));
        check("loop_drain", 32'(move_q.size()), 32'd0);

        // Short random route, random writes, enable drops and blocking
        for (int i = 0; i < NUM_SEG; i++) begin
            writeEntry(i, int'($urandom_range(1, 4)), int'($urandom_range(1, 6)));
        end
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                writeEntry(int'($urandom_range(0, NUM_SEG - 1)), int'($urandom_range(0, 7)),
                           int'($urandom_range(0, 6)));
            end
            applyFrame($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, 1'b0);
        end
        check("rand_seg", 32'(seg_idx), 32'(m_seg));

        // Reset on the 150th move of the default first segment
        @(negedge Clk);
        enable = 1'b0;
        Reset  = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        for (int i = 0; i < 149; i++) applyFrame(1'b1, 1'b0, 1'b0);
        applyFrame(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) applyFrame(1'b0, 1'b0, 1'b0);
        check("idle_busy", 32'(busy), 32'd0);

        repeat (4) @(negedge Clk);
        check("final_moves", 32'(move_q.size()), 32'd0);
        check("final_fires", 32'(fire_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
